univ_reg: RTL and testbench

- Parametrised universal register cell for the discrete-gate standard-cell library.
- It is the first sequential library element: a WIDTH-bit register with hold, load, shift, rotate, increment and decrement modes.
- It provides a registered carry/shift-out flag and a zero flag.
- Datapath blocks (PC, shifter, loop counters) instantiate it instead of hand-wiring flops around NAND/NOR/AOI cells.

---
 rtl/univ_reg.sv | 98 +++++++++
 tb/tb_univ_reg.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_reg.sv
// Universal WIDTH-bit register cell: hold, load, shift, rotate, increment, decrement.
// co is a registered carry/borrow/shift-out flag; zero is decoded combinationally from q.
`timescale 1ns/1ps
module univ_reg #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             zero
);

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
      $error("univ_reg: WIDTH must be in 2..32");
    end
  endgenerate

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_INC  = 3'b100;
  localparam logic [2:0] M_DEC  = 3'b101;
  localparam logic [2:0] M_ROL  = 3'b110;
  localparam logic [2:0] M_ROR  = 3'b111;

  localparam logic [WIDTH-1:0] RST_Q = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             co_q, co_d;

  always_comb begin
    q_d  = q_q;
    co_d = co_q;
    case (mode)
      M_HOLD: begin
        q_d  = q_q;
        co_d = co_q;
      end
      M_LOAD: begin
        q_d  = d;
        co_d = 1'b0;
      end
      M_SHL: begin
        q_d  = {q_q[WIDTH-2:0], sin};
        co_d = q_q[WIDTH-1];
      end
      M_SHR: begin
        q_d  = {sin, q_q[WIDTH-1:1]};
        co_d = q_q[0];
      end
      // co is status only; there is deliberately no carry-in to INC/DEC.
      M_INC: begin
        q_d  = q_q + ONE;
        co_d = &q_q;
      end
      M_DEC: begin
        q_d  = q_q - ONE;
        co_d = ~|q_q;
      end
      M_ROL: begin
        q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        co_d = q_q[WIDTH-1];
      end
      M_ROR: begin
        q_d  = {q_q[0], q_q[WIDTH-1:1]};
        co_d = q_q[0];
      end
      default: begin
        q_d  = q_q;
        co_d = co_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q  <= RST_Q;
      co_q <= 1'b0;
    end else if (en) begin
      q_q  <= q_d;
      co_q <= co_d;
    end
  end

  assign q    = q_q;
  assign co   = co_q;
  assign zero = (q_q == '0);

endmodule

// File: tb/tb_univ_reg.sv
// Scoreboard bench for univ_reg: 8-bit (reset 0xA5), 2-bit and 32-bit instances share stimulus.
`timescale 1ns/1ps
module tb_univ_reg;

  typedef struct {
    logic        rst;
    logic        en;
    logic [2:0]  mode;
    logic [31:0] d;
    logic        sin;
    logic [31:0] q;
    logic        co;
    logic        z;
  } vec_t;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011,
                         INC  = 3'b100, DEC  = 3'b101, ROL = 3'b110, ROR = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  mode = 3'b000;
  logic [31:0] d = 32'd0;
  logic        sin = 1'b0;

  logic [7:0]  q8;
  logic        co8, z8;
  logic [1:0]  q2;
  logic        co2, z2;
  logic [31:0] q32;
  logic        co32, z32;

  int checks = 0;
  int errors = 0;
  vec_t exp_q[$];

  always #5 clk = ~clk;

  univ_reg #(.WIDTH(8), .RESET_VALUE(32'hA5)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d[7:0]), .sin(sin),
    .q(q8), .co(co8), .zero(z8)
  );
  univ_reg #(.WIDTH(2), .RESET_VALUE(32'h0)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d[1:0]), .sin(sin),
    .q(q2), .co(co2), .zero(z2)
  );
  univ_reg #(.WIDTH(32), .RESET_VALUE(32'h0)) dut32 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin(sin),
    .q(q32), .co(co32), .zero(z32)
  );

  function automatic vec_t mk(logic r, logic e, logic [2:0] m, logic [31:0] dd, logic s,
                              logic [31:0] eq, logic ec, logic ez);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.d = dd; v.sin = s;
    v.q = eq; v.co = ec; v.z = ez;
    return v;
  endfunction

  function automatic vec_t observe(int w);
    vec_t o;
    o = mk(1'b0, 1'b0, 3'b000, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    if (w == 8) begin
      o.q = {24'd0, q8}; o.co = co8; o.z = z8;
    end else if (w == 2) begin
      o.q = {30'd0, q2}; o.co = co2; o.z = z2;
    end else begin
      o.q = q32; o.co = co32; o.z = z32;
    end
    return o;
  endfunction

  task automatic apply(vec_t v);
    rst = v.rst; en = v.en; mode = v.mode; d = v.d; sin = v.sin;
  endtask

  task automatic test_reset();
    vec_t v[$];
    vec_t e, o;
    v.push_back(mk(1, 0, LOAD, 32'h3C, 0, 32'hA5, 0, 0));
    v.push_back(mk(0, 1, LOAD, 32'h00, 0, 32'h00, 0, 1));
    foreach (v[i]) begin
      apply(v[i]); exp_q.push_back(v[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = observe(8); checks++;
      if (o.q !== e.q || o.co !== e.co || o.z !== e.z) begin
        errors++;
        $display("FAIL reset[%0d] got q=%h co=%b zero=%b want q=%h co=%b zero=%b",
                 i, o.q, o.co, o.z, e.q, e.co, e.z);
      end
      $display("reset[%0d] mode=%b q=%h co=%b zero=%b", i, v[i].mode, o.q, o.co, o.z);
    end
  endtask

  task automatic test_inc_dec();
    vec_t v[$];
    vec_t e, o;
    v.push_back(mk(0, 1, LOAD, 32'hFE, 0, 32'hFE, 0, 0));
    v.push_back(mk(0, 1, INC,  32'h00, 0, 32'hFF, 0, 0));
    v.push_back(mk(0, 1, INC,  32'h00, 1, 32'h00, 1, 1));
    v.push_back(mk(0, 1, DEC,  32'h00, 0, 32'hFF, 1, 0));
    v.push_back(mk(0, 1, DEC,  32'h00, 1, 32'hFE, 0, 0));
    foreach (v[i]) begin
      apply(v[i]); exp_q.push_back(v[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = observe(8); checks++;
      if (o.q !== e.q || o.co !== e.co || o.z !== e.z) begin
        errors++;
        $display("FAIL inc_dec[%0d] got q=%h co=%b zero=%b want q=%h co=%b zero=%b",
                 i, o.q, o.co, o.z, e.q, e.co, e.z);
      end
      $display("inc_dec[%0d] mode=%b q=%h co=%b zero=%b", i, v[i].mode, o.q, o.co, o.z);
    end
  endtask

  task automatic test_shift();
    vec_t v[$];
    vec_t e, o;
    v.push_back(mk(0, 1, LOAD, 32'h81, 1, 32'h81, 0, 0));
    v.push_back(mk(0, 1, SHL,  32'h00, 0, 32'h02, 1, 0));
    v.push_back(mk(0, 1, SHR,  32'h00, 1, 32'h81, 0, 0));
    v.push_back(mk(0, 1, SHR,  32'h00, 0, 32'h40, 1, 0));
    foreach (v[i]) begin
      apply(v[i]); exp_q.push_back(v[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = observe(8); checks++;
      if (o.q !== e.q || o.co !== e.co || o.z !== e.z) begin
        errors++;
        $display("FAIL shift[%0d] got q=%h co=%b zero=%b want q=%h co=%b zero=%b",
                 i, o.q, o.co, o.z, e.q, e.co, e.z);
      end
      $display("shift[%0d] mode=%b q=%h co=%b zero=%b", i, v[i].mode, o.q, o.co, o.z);
    end
  endtask

  task automatic test_rotate();
    vec_t v[$];
    vec_t e, o;
    v.push_back(mk(0, 1, LOAD, 32'h81, 0, 32'h81, 0, 0));
    v.push_back(mk(0, 1, ROL,  32'h00, 0, 32'h03, 1, 0));
    v.push_back(mk(0, 1, ROR,  32'h00, 0, 32'h81, 1, 0));
    v.push_back(mk(0, 1, ROR,  32'h00, 1, 32'hC0, 1, 0));
    v.push_back(mk(0, 1, ROL,  32'h00, 0, 32'h81, 1, 0));
    v.push_back(mk(0, 1, ROR,  32'h00, 1, 32'hC0, 1, 0));
    foreach (v[i]) begin
      apply(v[i]); exp_q.push_back(v[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = observe(8); checks++;
      if (o.q !== e.q || o.co !== e.co || o.z !== e.z) begin
        errors++;
        $display("FAIL rotate[%0d] got q=%h co=%b zero=%b want q=%h co=%b zero=%b",
                 i, o.q, o.co, o.z, e.q, e.co, e.z);
      end
      $display("rotate[%0d] mode=%b q=%h co=%b zero=%b", i, v[i].mode, o.q, o.co, o.z);
    end
  endtask

  task automatic test_enable();
    vec_t v[$];
    vec_t e, o;
    v.push_back(mk(0, 1, LOAD, 32'h10, 0, 32'h10, 0, 0));
    for (int k = 0; k < 5; k++) v.push_back(mk(0, 0, INC, 32'h55, k[0], 32'h10, 0, 0));
    v.push_back(mk(0, 1, LOAD, 32'h90, 0, 32'h90, 0, 0));
    v.push_back(mk(0, 1, SHL,  32'h00, 0, 32'h20, 1, 0));
    for (int k = 0; k < 5; k++) v.push_back(mk(0, 0, INC, 32'h00, 0, 32'h20, 1, 0));
    v.push_back(mk(0, 0, LOAD, 32'h00, 0, 32'h20, 1, 0));
    v.push_back(mk(0, 1, HOLD, 32'h77, 1, 32'h20, 1, 0));
    v.push_back(mk(1, 0, INC,  32'h00, 0, 32'hA5, 0, 0));
    foreach (v[i]) begin
      apply(v[i]); exp_q.push_back(v[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = observe(8); checks++;
      if (o.q !== e.q || o.co !== e.co || o.z !== e.z) begin
        errors++;
        $display("FAIL enable[%0d] got q=%h co=%b zero=%b want q=%h co=%b zero=%b",
                 i, o.q, o.co, o.z, e.q, e.co, e.z);
      end
      $display("enable[%0d] en=%b mode=%b q=%h co=%b zero=%b", i, v[i].en, v[i].mode, o.q, o.co, o.z);
    end
  endtask

  task automatic test_reset_priority();
    vec_t v[$];
    vec_t e, o;
    v.push_back(mk(0, 1, LOAD, 32'hFF, 0, 32'hFF, 0, 0));
    v.push_back(mk(0, 1, INC,  32'h00, 0, 32'h00, 1, 1));
    v.push_back(mk(1, 1, DEC,  32'h00, 0, 32'hA5, 0, 0));
    v.push_back(mk(1, 1, LOAD, 32'h12, 0, 32'hA5, 0, 0));
    v.push_back(mk(0, 1, INC,  32'h00, 0, 32'hA6, 0, 0));
    foreach (v[i]) begin
      apply(v[i]); exp_q.push_back(v[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = observe(8); checks++;
      if (o.q !== e.q || o.co !== e.co || o.z !== e.z) begin
        errors++;
        $display("FAIL rst_prio[%0d] got q=%h co=%b zero=%b want q=%h co=%b zero=%b",
                 i, o.q, o.co, o.z, e.q, e.co, e.z);
      end
      $display("rst_prio[%0d] rst=%b mode=%b q=%h co=%b zero=%b", i, v[i].rst, v[i].mode, o.q, o.co, o.z);
    end
  endtask

  task automatic test_width2();
    vec_t v[$];
    vec_t e, o;
    v.push_back(mk(1, 0, LOAD, 32'h3, 0, 32'h0, 0, 1));
    v.push_back(mk(0, 1, INC,  32'h0, 0, 32'h1, 0, 0));
    v.push_back(mk(0, 1, INC,  32'h0, 0, 32'h2, 0, 0));
    v.push_back(mk(0, 1, INC,  32'h0, 0, 32'h3, 0, 0));
    v.push_back(mk(0, 1, INC,  32'h0, 0, 32'h0, 1, 1));
    v.push_back(mk(0, 1, SHL,  32'h0, 1, 32'h1, 0, 0));
    v.push_back(mk(0, 1, ROR,  32'h0, 0, 32'h2, 1, 0));
    foreach (v[i]) begin
      apply(v[i]); exp_q.push_back(v[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = observe(2); checks++;
      if (o.q !== e.q || o.co !== e.co || o.z !== e.z) begin
        errors++;
        $display("FAIL width2[%0d] got q=%h co=%b zero=%b want q=%h co=%b zero=%b",
                 i, o.q, o.co, o.z, e.q, e.co, e.z);
      end
      $display("width2[%0d] mode=%b q=%h co=%b zero=%b", i, v[i].mode, o.q, o.co, o.z);
    end
  endtask

  task automatic test_width32();
    vec_t v[$];
    vec_t e, o;
    v.push_back(mk(1, 0, HOLD, 32'h0,        0, 32'h0,        0, 1));
    v.push_back(mk(0, 1, LOAD, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 0));
    v.push_back(mk(0, 1, INC,  32'h0,        0, 32'h0,        1, 1));
    v.push_back(mk(0, 1, DEC,  32'h0,        0, 32'hFFFFFFFF, 1, 0));
    v.push_back(mk(0, 1, SHR,  32'h0,        0, 32'h7FFFFFFF, 1, 0));
    v.push_back(mk(0, 1, ROL,  32'h0,        1, 32'hFFFFFFFE, 0, 0));
    foreach (v[i]) begin
      apply(v[i]); exp_q.push_back(v[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = observe(32); checks++;
      if (o.q !== e.q || o.co !== e.co || o.z !== e.z) begin
        errors++;
        $display("FAIL width32[%0d] got q=%h co=%b zero=%b want q=%h co=%b zero=%b",
                 i, o.q, o.co, o.z, e.q, e.co, e.z);
      end
      $display("width32[%0d] mode=%b q=%h co=%b zero=%b", i, v[i].mode, o.q, o.co, o.z);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_inc_dec();
    test_shift();
    test_rotate();
    test_enable();
    test_reset_priority();
    test_width2();
    test_width32();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
